disp_scan_ctrl: RTL and testbench

//  Scan scheduler for the 4-digit common-anode seven-segment display on the debounce test boards.

---
 rtl/disp_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit common-anode seven-segment scan scheduler
// with frame-synchronous updates, leading-zero blanking and PWM.
module disp_scan_ctrl #(
  parameter int SUB_CYCLES = 6250,
  parameter int SUB_W      = 13
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic [3:0] hex3,
  input  logic [3:0] hex2,
  input  logic [3:0] hex1,
  input  logic [3:0] hex0,
  input  logic [3:0] dp_in,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic       blank_lz,
  input  logic [2:0] bright,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic [1:0] digit_sel,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } state_t;

  localparam logic [SUB_W-1:0] SUB_LAST =
    SUB_W'(SUB_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_PRE =
    SUB_W'(SUB_CYCLES - 2);

  state_t           state;
  state_t           state_nx;
  logic [SUB_W-1:0] sub_cnt;
  logic [2:0]       phase;
  logic [2:0]       bright_q;

  logic [3:0][3:0]  act_h;
  logic [3:0][3:0]  pend_h;
  logic [3:0]       act_dp;
  logic [3:0]       pend_dp;
  logic             pending_full;

  logic             sub_wrap;
  logic             ph_wrap;
  logic             slot_start;
  logic             last_cyc;
  logic             pre_last;
  logic [1:0]       idx;
  logic [3:0]       blank;
  logic             dig_on;
  logic [3:0]       an_nx;
  logic [7:0]       sseg_nx;

  function automatic logic [6:0] seg7(
    input logic [3:0] h
  );
    logic [6:0] s;
    s = 7'h7F;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign sub_wrap   = (sub_cnt == SUB_LAST);
  assign ph_wrap    = sub_wrap && (phase == 3'd7);
  assign slot_start = (phase == 3'd0) &&
                      (sub_cnt == '0);
  assign last_cyc   = ph_wrap && (state == D3);
  assign pre_last   = (state == D3) &&
                      (phase == 3'd7) &&
                      (sub_cnt == SUB_PRE);
  assign upd_ready  = ~pending_full;
  assign idx        = state;

  always_comb begin
    state_nx = D0;
    unique case (state)
      D0: state_nx = D1;
      D1: state_nx = D2;
      D2: state_nx = D3;
      D3: state_nx = D0;
    endcase
  end

  // a digit is blank only while every digit to its left is zero too
  always_comb begin
    blank    = '0;
    blank[3] = blank_lz && (act_h[3] == 4'h0);
    blank[2] = blank[3] && (act_h[2] == 4'h0);
    blank[1] = blank[2] && (act_h[1] == 4'h0);
  end

  always_comb begin
    dig_on  = (phase <= bright_q) && !blank[idx];
    an_nx   = 4'hF;
    sseg_nx = 8'hFF;
    if (dig_on) begin
      an_nx[idx] = 1'b0;
      sseg_nx    = {act_dp[idx], seg7(act_h[idx])};
    end
  end

  always_ff @(posedge clk_amisha or
              negedge reset_amisha) begin
    if (!reset_amisha) begin
      state      <= D0;
      sub_cnt    <= '0;
      phase      <= '0;
      bright_q   <= '0;
      an         <= 4'hF;
      sseg       <= 8'hFF;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap) begin
        phase <= phase + 3'd1;
      end
      if (ph_wrap) begin
        state <= state_nx;
      end
      if (slot_start) begin
        bright_q <= bright;
      end
      // registered one cycle early so it lines up with last_cyc
      frame_tick <= pre_last;
      an         <= an_nx;
      sseg       <= sseg_nx;
      digit_sel  <= idx;
    end
  end

  // pending never commits in the cycle it was captured
  always_ff @(posedge clk_amisha or
              negedge reset_amisha) begin
    if (!reset_amisha) begin
      act_h        <= '0;
      pend_h       <= '0;
      act_dp       <= 4'hF;
      pend_dp      <= 4'hF;
      pending_full <= 1'b0;
    end else if (last_cyc && pending_full) begin
      act_h        <= pend_h;
      act_dp       <= pend_dp;
      pending_full <= 1'b0;
    end else if (upd_valid && !pending_full) begin
      pend_h       <= {hex3, hex2, hex1, hex0};
      pend_dp      <= dp_in;
      pending_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: vector table, hand sequences and a
// position-based reference model for disp_scan_ctrl.
module tb_disp_scan_ctrl;

  localparam int SC    = 2;
  localparam int SLOT  = 8 * SC;
  localparam int FRAME = 4 * SLOT;

  logic       clk_amisha   = 1'b0;
  logic       reset_amisha = 1'b0;
  logic [3:0] hex3 = 4'h0;
  logic [3:0] hex2 = 4'h0;
  logic [3:0] hex1 = 4'h0;
  logic [3:0] hex0 = 4'h0;
  logic [3:0] dp_in = 4'hF;
  logic       upd_valid = 1'b0;
  logic       blank_lz = 1'b1;
  logic [2:0] bright = 3'd7;
  logic       upd_ready;
  logic       frame_tick;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [1:0] digit_sel;

  disp_scan_ctrl #(
    .SUB_CYCLES(SC),
    .SUB_W(2)
  ) dut (
    .clk_amisha  (clk_amisha),
    .reset_amisha(reset_amisha),
    .hex3        (hex3),
    .hex2        (hex2),
    .hex1        (hex1),
    .hex0        (hex0),
    .dp_in       (dp_in),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .blank_lz    (blank_lz),
    .bright      (bright),
    .an          (an),
    .sseg        (sseg),
    .digit_sel   (digit_sel),
    .frame_tick  (frame_tick)
  );

  always #5 clk_amisha = ~clk_amisha;

  int total = 0;
  int bad   = 0;

  logic [6:0] segtab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [3:0] h;
    logic       dp;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [16];

  int         k;
  logic [3:0] m_act [4];
  logic [3:0] m_pend [4];
  logic [3:0] m_adp;
  logic [3:0] m_pdp;
  bit         m_full;
  int         m_bq;
  logic [3:0] e_an;
  logic [7:0] e_sseg;
  logic [1:0] e_sel;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_full = 1'b0;
    m_bq   = 0;
    m_adp  = 4'hF;
    m_pdp  = 4'hF;
    for (int j = 0; j < 4; j++) begin
      m_act[j]  = 4'h0;
      m_pend[j] = 4'h0;
    end
    e_an   = 4'hF;
    e_sseg = 8'hFF;
    e_sel  = 2'd0;
  endtask

  // predicts outputs after the coming edge from the
  // position of the scan within the frame
  task automatic model_edge();
    int pos, d, ph;
    bit blk, on;
    pos = k % FRAME;
    d   = pos / SLOT;
    ph  = (pos % SLOT) / SC;
    blk = 1'b0;
    if (blank_lz && d > 0) begin
      blk = 1'b1;
      for (int j = d; j < 4; j++)
        if (m_act[j] != 4'h0) blk = 1'b0;
    end
    on     = (ph <= m_bq) && !blk;
    e_sel  = 2'(d);
    e_an   = 4'hF;
    e_sseg = 8'hFF;
    if (on) begin
      e_an[d] = 1'b0;
      e_sseg  = {m_adp[d], segtab[m_act[d]]};
    end
    if (pos % SLOT == 0) m_bq = int'(bright);
    if (pos == FRAME - 1 && m_full) begin
      m_act  = m_pend;
      m_adp  = m_pdp;
      m_full = 1'b0;
    end else if (upd_valid && !m_full) begin
      m_pend[3] = hex3;
      m_pend[2] = hex2;
      m_pend[1] = hex1;
      m_pend[0] = hex0;
      m_pdp     = dp_in;
      m_full    = 1'b1;
    end
    k++;
  endtask

  task automatic cyc();
    model_edge();
    @(negedge clk_amisha);
    chk("an", an, e_an);
    chk("sseg", sseg, e_sseg);
    chk("digit_sel", digit_sel, e_sel);
    chk("frame_tick", frame_tick,
        (k % FRAME) == FRAME - 1);
    chk("upd_ready", upd_ready, !m_full);
  endtask

  task automatic chk_rst();
    chk("rst_an", an, 4'hF);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_tick", frame_tick, 0);
    chk("rst_ready", upd_ready, 1);
    chk("rst_sel", digit_sel, 0);
  endtask

  task automatic run_to(input int t);
    while (k % FRAME != t) cyc();
  endtask

  task automatic send(input logic [3:0] a,
                      input logic [3:0] b,
                      input logic [3:0] c,
                      input logic [3:0] d,
                      input logic [3:0] dp);
    int n = 0;
    while (!upd_ready && n < 3 * FRAME) begin
      cyc();
      n++;
    end
    chk("send_ready", upd_ready, 1);
    hex3 = a; hex2 = b; hex1 = c; hex0 = d;
    dp_in = dp;
    upd_valid = 1'b1;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic wait_commit();
    int n = 0;
    while (!upd_ready && n < 3 * FRAME) begin
      cyc();
      n++;
    end
    chk("commit", upd_ready, 1);
  endtask

  task automatic count_slot(input logic [3:0] pat,
                            input int chg_at,
                            input logic [2:0] nb,
                            output int n);
    n = 0;
    for (int i = 0; i < SLOT; i++) begin
      if (i == chg_at) bright = nb;
      if (an == pat) n++;
      cyc();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n, n2, n3, n4, caps;

    tv[0]  = '{4'h0, 1'b1, 8'hC0};
    tv[1]  = '{4'h1, 1'b0, 8'h79};
    tv[2]  = '{4'h2, 1'b1, 8'hA4};
    tv[3]  = '{4'h3, 1'b1, 8'hB0};
    tv[4]  = '{4'h4, 1'b0, 8'h19};
    tv[5]  = '{4'h5, 1'b1, 8'h92};
    tv[6]  = '{4'h6, 1'b1, 8'h82};
    tv[7]  = '{4'h7, 1'b0, 8'h78};
    tv[8]  = '{4'h8, 1'b1, 8'h80};
    tv[9]  = '{4'h9, 1'b1, 8'h90};
    tv[10] = '{4'hA, 1'b0, 8'h08};
    tv[11] = '{4'hB, 1'b1, 8'h83};
    tv[12] = '{4'hC, 1'b1, 8'hC6};
    tv[13] = '{4'hD, 1'b0, 8'h21};
    tv[14] = '{4'hE, 1'b1, 8'h86};
    tv[15] = '{4'hF, 1'b1, 8'h8E};

    // reset and free-running scan
    model_reset();
    repeat (3) begin
      @(negedge clk_amisha);
      chk_rst();
    end
    reset_amisha = 1'b1;
    n = 0; n2 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      if (frame_tick) n++;
      if (an != 4'hE && an != 4'hF) n2++;
    end
    chk("t1_ticks", n, 2);
    chk("t1_only_d0", n2, 0);

    // decode table
    blank_lz = 1'b0;
    bright   = 3'd7;
    for (int i = 0; i < 16; i++) begin
      send(tv[i].h, tv[i].h, tv[i].h, tv[i].h,
           {4{tv[i].dp}});
      wait_commit();
      run_to(2);
      chk("vec_an", an, 4'hE);
      chk("vec_sseg", sseg, tv[i].exp);
    end

    // frame-synchronous update
    run_to(5);
    send(4'h1, 4'h2, 4'h3, 4'h4, 4'b1011);
    chk("t2_busy", upd_ready, 0);
    n = 0;
    while (!frame_tick && n < 2 * FRAME) begin
      chk("t2_hold", upd_ready, 0);
      cyc();
      n++;
    end
    chk("t2_tick", frame_tick, 1);
    chk("t2_tick_busy", upd_ready, 0);
    cyc();
    chk("t2_ready", upd_ready, 1);
    run_to(2);
    chk("t2_an0", an, 4'hE);
    chk("t2_seg0", sseg, 8'h99);
    run_to(18);
    chk("t2_an1", an, 4'hD);
    chk("t2_seg1", sseg, 8'hB0);
    run_to(34);
    chk("t2_an2", an, 4'hB);
    chk("t2_seg2", sseg, 8'h24);
    run_to(50);
    chk("t2_an3", an, 4'h7);
    chk("t2_seg3", sseg, 8'hF9);

    // brightness duty, including a mid-slot change
    bright = 3'd0;
    run_to(17);
    count_slot(4'hD, -1, 3'd0, n);
    chk("t3_duty0", n, 2);
    bright = 3'd3;
    run_to(49);
    count_slot(4'h7, -1, 3'd3, n);
    chk("t3_duty3", n, 8);
    count_slot(4'hE, 5, 3'd0, n);
    chk("t3_midslot", n, 8);
    count_slot(4'hD, -1, 3'd0, n);
    chk("t3_next", n, 2);

    // leading-zero blanking
    bright = 3'd7;
    blank_lz = 1'b1;
    send(4'h0, 4'h0, 4'h5, 4'h0, 4'hF);
    wait_commit();
    run_to(1);
    n = 0; n2 = 0; n3 = 0; n4 = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (!an[3]) n++;
      if (!an[2]) n2++;
      if (an == 4'hD && sseg == 8'h92) n3++;
      if (an == 4'hE && sseg == 8'hC0) n4++;
      cyc();
    end
    chk("t4_an3", n, 0);
    chk("t4_an2", n2, 0);
    chk("t4_d1", n3, SLOT);
    chk("t4_d0", n4, SLOT);
    blank_lz = 1'b0;
    n = 0; n2 = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (an == 4'h7 && sseg == 8'hC0) n++;
      if (an == 4'hB && sseg == 8'hC0) n2++;
      cyc();
    end
    chk("t4_lit3", n, SLOT);
    chk("t4_lit2", n2, SLOT);

    // continuous valid with random data
    run_to(0);
    caps = 0;
    upd_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      hex3  = 4'($urandom_range(15));
      hex2  = 4'($urandom_range(15));
      hex1  = 4'($urandom_range(15));
      hex0  = 4'($urandom_range(15));
      dp_in = 4'($urandom_range(15));
      bright = 3'($urandom_range(7));
      if (i % FRAME == 0)
        blank_lz = 1'($urandom_range(1));
      if (upd_valid && upd_ready) caps++;
      cyc();
    end
    upd_valid = 1'b0;
    chk("t5_caps", caps, 4);

    // async reset mid-slot of D2 drops pending data
    bright = 3'd7;
    blank_lz = 1'b0;
    send(4'h9, 4'h9, 4'h9, 4'h9, 4'h0);
    chk("t6_pend", upd_ready, 0);
    run_to(40);
    chk("t6_in_d2", digit_sel, 2);
    #2 reset_amisha = 1'b0;
    #1;
    chk("t6_async_an", an, 4'hF);
    chk("t6_async_sseg", sseg, 8'hFF);
    model_reset();
    repeat (2) begin
      @(negedge clk_amisha);
      chk_rst();
    end
    reset_amisha = 1'b1;
    cyc();
    chk("t6_an", an, 4'hE);
    chk("t6_sel", digit_sel, 0);
    chk("t6_sseg", sseg, 8'hC0);
    n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (an == 4'h7 && sseg == 8'hC0) n++;
      cyc();
    end
    chk("t6_zero_d3", n, 2 * SLOT);
    chk("t6_ready", upd_ready, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
